sound_dsm_dac: RTL and testbench

Output stage directly downstream of the cartridge sound source. It consumes the signed SCC sample stream from the SOUND_IF signal, applies a 4-bit volume with a serial shift-add multiplier, and converts the result to offset binary. A first-order delta-sigma modulator then drives a 1-bit audio pin through an external RC filter. All logic advances only on CLK_EN, the 21 MHz enable used elsewhere in the cartridge.

---
 rtl/sound_dac_pkg.sv | 20 ++
 rtl/sound_dsm.sv | 39 +++
 rtl/sound_dsm_dac.sv | 143 ++++++++++++++
 tb/tb_sound_dsm_dac.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sound_dac_pkg.sv
// Shared types and constants for the cartridge sound output stage:
// multiplier FSM states, shift-add step count and the modulator midscale level.
package sound_dac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    LOAD = 2'd2
  } state_e;

  localparam int unsigned MUL_STEPS  = 5;
  localparam int unsigned GAIN_SHIFT = 4;
  localparam int unsigned STEP_W     = 3;

  // Offset-binary zero point for an in_w-bit signed sample.
  function automatic logic [31:0] midscale(input int unsigned in_w);
    return 32'(1) << (in_w - 1);
  endfunction

endpackage

// File: rtl/sound_dsm.sv
// First-order delta-sigma modulator: the carry out of acc+level is the 1-bit
// output, so over 2^IN_W enables the number of ones equals level.
module sound_dsm #(
  parameter int unsigned IN_W = 11
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            CLK_EN,
  input  logic [IN_W-1:0] level,
  output logic            DAC_OUT
);

  logic [IN_W-1:0] acc_q, acc_d;
  logic            dac_q, dac_d;
  logic [IN_W:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, level};
    acc_d = acc_q;
    dac_d = dac_q;
    if (CLK_EN) begin
      acc_d = sum[IN_W-1:0];
      dac_d = sum[IN_W];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc_q <= '0;
      dac_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      dac_q <= dac_d;
    end
  end

  assign DAC_OUT = dac_q;

endmodule

// File: rtl/sound_dsm_dac.sv
// Sound output stage: volume scaling with a serial MSB-first shift-add
// multiplier, offset-binary conversion and a 1-bit delta-sigma output.
module sound_dsm_dac
  import sound_dac_pkg::*;
#(
  parameter int unsigned IN_W  = 11,
  parameter int unsigned VOL_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CLK_EN,
  input  logic [IN_W-1:0]  SAMPLE_IN,
  input  logic             SAMPLE_VALID,
  input  logic [VOL_W-1:0] VOLUME,
  input  logic             MUTE,
  output logic             DAC_OUT,
  output logic             BUSY,
  output logic             OVERRUN
);

  localparam int unsigned MULT_W = VOL_W + 1;
  localparam int unsigned PROD_W = IN_W + MULT_W;
  localparam logic [IN_W-1:0] MID = IN_W'(midscale(IN_W));

  state_e                   state_q, state_d;
  logic signed [IN_W-1:0]   sample_q, sample_d;
  logic [MULT_W-1:0]        mult_q, mult_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic [STEP_W-1:0]        step_q, step_d;
  logic [IN_W-1:0]          pend_q, pend_d;
  logic                     pend_vld_q, pend_vld_d;
  logic [IN_W-1:0]          level_q, level_d;
  logic                     busy_q, busy_d;
  logic                     overrun_q, overrun_d;

  logic                     start;
  logic [IN_W-1:0]          start_sample;
  logic signed [PROD_W-1:0] addend;

  always_comb begin
    state_d      = state_q;
    sample_d     = sample_q;
    mult_d       = mult_q;
    prod_d       = prod_q;
    step_d       = step_q;
    pend_d       = pend_q;
    pend_vld_d   = pend_vld_q;
    level_d      = level_q;
    overrun_d    = 1'b0;
    start        = 1'b0;
    start_sample = SAMPLE_IN;
    addend       = mult_q[step_q] ? PROD_W'(sample_q) : '0;

    if (CLK_EN) begin
      case (state_q)
        IDLE: begin
          if (SAMPLE_VALID) begin
            start = 1'b1;
          end
        end
        MUL: begin
          prod_d = (prod_q <<< 1) + addend;
          if (step_q == '0) begin
            state_d = LOAD;
          end else begin
            step_d = step_q - STEP_W'(1);
          end
          // One-deep holding slot; a second arrival replaces the first.
          if (SAMPLE_VALID) begin
            overrun_d  = pend_vld_q;
            pend_d     = SAMPLE_IN;
            pend_vld_d = 1'b1;
          end
        end
        LOAD: begin
          level_d = MUTE ? MID : IN_W'(prod_q >>> GAIN_SHIFT) + MID;
          if (SAMPLE_VALID) begin
            start      = 1'b1;
            overrun_d  = pend_vld_q;
            pend_vld_d = 1'b0;
          end else if (pend_vld_q) begin
            start        = 1'b1;
            start_sample = pend_q;
            pend_vld_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      if (start) begin
        sample_d = start_sample;
        mult_d   = MULT_W'(VOLUME) + MULT_W'(1);
        prod_d   = '0;
        step_d   = STEP_W'(MUL_STEPS - 1);
        state_d  = MUL;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      sample_q   <= '0;
      mult_q     <= '0;
      prod_q     <= '0;
      step_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      level_q    <= MID;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sample_q   <= sample_d;
      mult_q     <= mult_d;
      prod_q     <= prod_d;
      step_q     <= step_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      level_q    <= level_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  sound_dsm #(
    .IN_W(IN_W)
  ) u_dsm (
    .CLK    (CLK),
    .RESET  (RESET),
    .CLK_EN (CLK_EN),
    .level  (level_q),
    .DAC_OUT(DAC_OUT)
  );

  assign BUSY    = busy_q;
  assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_sound_dsm_dac.sv
// Directed bench for sound_dsm_dac: levels are measured as the count of ones
// over 2048 enables, which equals the loaded level exactly.
module tb_sound_dsm_dac;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CLK_EN = 1'b1;
  logic [10:0] SAMPLE_IN = '0;
  logic        SAMPLE_VALID = 1'b0;
  logic [3:0]  VOLUME = 4'd15;
  logic        MUTE = 1'b0;
  logic        DAC_OUT, BUSY, OVERRUN;

  int checks = 0;
  int failures = 0;
  int ov_cnt = 0;

  sound_dsm_dac #(.IN_W(11), .VOL_W(4)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .CLK_EN      (CLK_EN),
    .SAMPLE_IN   (SAMPLE_IN),
    .SAMPLE_VALID(SAMPLE_VALID),
    .VOLUME      (VOLUME),
    .MUTE        (MUTE),
    .DAC_OUT     (DAC_OUT),
    .BUSY        (BUSY),
    .OVERRUN     (OVERRUN)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    ov_cnt += int'(OVERRUN);
  endtask

  task automatic count_ones(input int n, output int ones);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      ones += int'(DAC_OUT);
    end
  endtask

  task automatic dac_pattern(input string tag);
    logic [3:0] pat;
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pat = {pat[2:0], DAC_OUT};
    end
    chk(tag, int'(pat), 5);
  endtask

  task automatic run_sample(input string tag, input int s, input int vol, input int exp_level);
    int ones;
    SAMPLE_IN    = 11'(s);
    VOLUME       = 4'(vol);
    SAMPLE_VALID = 1'b1;
    tick();
    SAMPLE_VALID = 1'b0;
    chk({tag, "_busy_start"}, int'(BUSY), 1);
    repeat (5) tick();
    chk({tag, "_busy_load"}, int'(BUSY), 1);
    tick();
    chk({tag, "_busy_done"}, int'(BUSY), 0);
    count_ones(2048, ones);
    chk({tag, "_level"}, ones, exp_level);
  endtask

  initial begin
    int ones;
    int bad;
    logic all_busy;
    logic dac0;

    // Reset state, then idle modulator at midscale
    tick();
    tick();
    chk("rst_dac", int'(DAC_OUT), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_overrun", int'(OVERRUN), 0);
    RESET = 1'b0;
    dac_pattern("rst_toggle");

    run_sample("zero_v15", 0, 15, 1024);
    run_sample("max_v15", 1023, 15, 2047);
    run_sample("min_v0", -1024, 0, 960);
    run_sample("neg1_v0", -1, 0, 1023);
    MUTE = 1'b1;
    run_sample("mute", 500, 15, 1024);
    MUTE = 1'b0;

    // Two arrivals while multiplying: one overrun, last sample wins
    ov_cnt = 0;
    VOLUME = 4'd15;
    SAMPLE_IN = 11'(100);
    SAMPLE_VALID = 1'b1;
    tick();
    all_busy = BUSY;
    SAMPLE_IN = 11'(200);
    tick();
    all_busy &= BUSY;
    SAMPLE_IN = 11'(-512);
    tick();
    all_busy &= BUSY;
    SAMPLE_VALID = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      all_busy &= BUSY;
    end
    chk("ovr_busy_through", int'(all_busy), 1);
    tick();
    chk("ovr_busy_done", int'(BUSY), 0);
    chk("ovr_pulses", ov_cnt, 1);
    count_ones(2048, ones);
    chk("ovr_level", ones, 512);

    // CLK_EN low freezes everything and ignores SAMPLE_VALID
    ov_cnt = 0;
    SAMPLE_IN = 11'(300);
    SAMPLE_VALID = 1'b1;
    tick();
    SAMPLE_VALID = 1'b0;
    tick();
    tick();
    dac0 = DAC_OUT;
    CLK_EN = 1'b0;
    SAMPLE_VALID = 1'b1;
    SAMPLE_IN = 11'(7);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (DAC_OUT !== dac0) bad++;
      if (BUSY !== 1'b1) bad++;
    end
    chk("frz_hold", bad, 0);
    CLK_EN = 1'b1;
    SAMPLE_VALID = 1'b0;
    repeat (3) tick();
    chk("frz_busy_resume", int'(BUSY), 1);
    tick();
    chk("frz_busy_done", int'(BUSY), 0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (BUSY !== 1'b0) bad++;
    end
    chk("frz_no_pending", bad, 0);
    chk("frz_overrun", ov_cnt, 0);
    count_ones(2048, ones);
    chk("frz_level", ones, 1324);

    // Reset at MUL step 2 with a sample pending
    SAMPLE_IN = 11'(1023);
    SAMPLE_VALID = 1'b1;
    tick();
    SAMPLE_IN = 11'(200);
    tick();
    SAMPLE_VALID = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("mrst_busy", int'(BUSY), 0);
    chk("mrst_dac", int'(DAC_OUT), 0);
    dac_pattern("mrst_toggle");
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (BUSY !== 1'b0) bad++;
    end
    chk("mrst_no_pending", bad, 0);
    count_ones(2048, ones);
    chk("mrst_level", ones, 1024);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
